// File: rtl/uart_rx_if.sv
// Signal bundle between the RX pad/config side (master) and the uart_rx core (slave).
// The interface parameters must match the parameters of the uart_rx instance that uses it.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic [PRESC_W-1:0]    PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// optional parity, framing check; pulses DATA_VALID / PAR_ERR / STP_ERR for one cycle.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic                  rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]            sync_vld_q;
  logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [2:0]            smp_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [PRESC_W-1:0]    presc_q;
  logic                  par_en_q, par_typ_q, par_bad_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q, par_err_q, stp_err_q;

  logic [PRESC_W-1:0]    half;
  logic                  bit_end, maj, fall;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign half    = presc_q >> 1;
  assign bit_end = (edge_cnt_q == presc_q - PRESC_W'(1));
  assign maj     = majority3(smp_q);
  // rx_prev_q is only 1 once a real (post-synchronizer) high has been seen
  assign fall    = rx_prev_q & ~rx_s_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q + PRESC_W'(1);
    if (state_q == IDLE || bit_end) edge_cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b0;
      sync_vld_q   <= '0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '0;
      word_q       <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      rx_meta_q    <= bus.RX_IN;
      rx_s_q       <= rx_meta_q;
      sync_vld_q   <= {sync_vld_q[0], 1'b1};
      rx_prev_q    <= sync_vld_q[1] & rx_s_q;
      edge_cnt_q   <= edge_cnt_d;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;

      if (state_q != IDLE) begin
        if (edge_cnt_q == half - PRESC_W'(1)) smp_q[0] <= rx_s_q;
        if (edge_cnt_q == half)               smp_q[1] <= rx_s_q;
        if (edge_cnt_q == half + PRESC_W'(1)) smp_q[2] <= rx_s_q;
      end

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (fall) begin
            state_q   <= START;
            presc_q   <= bus.PRESCALE;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            par_bad_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) state_q <= maj ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            word_q[bit_cnt_q] <= maj;
            if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_bad_q <= maj ^ (^word_q) ^ par_typ_q;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q   <= IDLE;
            // The decision lands on the first low cycle of a back-to-back start bit,
            // so a good stop bit stands in as the "previous high" for edge detection.
            rx_prev_q <= maj;
            par_err_q <= par_bad_q;
            stp_err_q <= ~maj;
            if (maj && !par_bad_q) begin
              p_data_q     <= word_q;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.PAR_ERR    = par_err_q;
  assign bus.STP_ERR    = stp_err_q;

endmodule
